sprite_rom_arbiter: RTL
=======================

// Module: sprite_rom_arbiter
// PURPOSE
// - Shares one single-port sprite ROM (address in, palette index out) among NUM_REQ requesters,
//   e.g. board scanout, piece overlay, and the checkmate/stalemate banner.
// - Round-robin arbitration with one grant per vga_clk. ROM read latency is hidden behind a
//   tagged response pipeline. Sits between the pixel generators and the ROM/palette pair.
// PARAMETERS
// - NUM_REQ  4   number of requesters (2..8)
// - ADDR_W   12  ROM address width
// - DATA_W   2   ROM word width (palette index)
// - ROM_LAT  1   vga_clk posedges from the edge that loads rom_addr to the edge that captures rom_q
// PORTS
// - vga_clk    in   1               sole clock, posedge
// - reset      in   1               synchronous, active-high
// - req        in   NUM_REQ         request per requester; held until granted
// - req_addr   in   NUM_REQ*ADDR_W  address of requester i in bits [i*ADDR_W +: ADDR_W]
// - gnt        out  NUM_REQ         one-hot grant, combinational, same cycle as req
// - rom_addr   out  ADDR_W          registered address to ROM
// - rom_q      in   DATA_W          ROM read data
// - rsp_valid  out  1               response valid, one cycle
// - rsp_id     out  $clog2(NUM_REQ) requester index of the response
// - rsp_data   out  DATA_W          captured rom_q
// BEHAVIOUR
// - Reset values (also on reset mid-operation):
//   - gnt=0, rom_addr=0, rsp_valid=0, rsp_id=0, rsp_data=0.
//   - RR pointer=0. Tag/valid pipeline flushed; in-flight reads are dropped and never responded.
// - Arbitration: search from pointer p upward, modulo NUM_REQ. The first i with req[i]=1 gets gnt[i].
//   - At most one gnt bit set. gnt=0 while reset is high.
//   - After a grant to i: p <= (i+1) mod NUM_REQ. With no request: p and rom_addr hold.
// - Grant in cycle N: rom_addr <= req_addr[i] at the end of N; tag {valid=1, id=i} enters the pipeline.
// - Pipeline depth ROM_LAT+1. Response appears in cycle N+1+ROM_LAT (cycle N+2 at default):
//   rsp_valid=1, rsp_id=i, rsp_data=rom_q. rsp_data holds its value when rsp_valid=0.
// - Throughput: one grant per cycle. Back-to-back grants produce back-to-back responses in grant order.
// - Requester protocol: req may drop only after gnt is seen. A requester re-asserting in the next cycle
//   is legal but waits behind the other active requesters under RR.
// - Fairness: with all NUM_REQ asserting continuously, each is granted exactly once every NUM_REQ cycles.
// - Wrap: p = NUM_REQ-1 with grant there -> p = 0.
// CONFIGURATION
// - SPRITE_ARB_PRIO0_EN defined: requester 0 (video scanout) has strict priority.
//   - req[0]=1 always grants 0 and p does not change.
//   - Other requesters use RR only in cycles with req[0]=0.
// - Undefined: pure round-robin across all requesters, requester 0 included.
// TESTING
// - Reset then idle: req=0 for 10 cycles -> gnt=0, rsp_valid=0 throughout, rom_addr=0.
// - Single read: req[2]=1 with addr 0x0A5 in cycle 0 -> gnt=4'b0100 in cycle 0, rom_addr=0x0A5 in cycle 1,
//   rsp_valid=1, rsp_id=2, rsp_data=ROM[0x0A5] in cycle 2.
// - All four requesting for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3;
//   responses follow with the same ids, 2 cycles later.
// - Wrap: p=3, req=4'b1001 -> grant 3, then next cycle grant 0.
// - Reset mid-flight: grant in cycle 0, reset high in cycle 1 -> no rsp_valid in cycle 2; p=0 afterwards.
// - SPRITE_ARB_PRIO0_EN: req=4'b1111 held -> gnt=4'b0001 every cycle. Drop req[0] -> grants 1,2,3,1...
//   Undefined build -> 0,1,2,3.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_rom_arbiter
// Brief    : Round-robin sharing of one sprite ROM among NUM_REQ requesters,
//            with a tagged pipeline returning each read to its requester.
//            Define SPRITE_ARB_PRIO0_EN to give requester 0 strict priority.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 2,
    parameter int ROM_LAT = 1
) (
    input  logic                        vga_clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [DATA_W-1:0]           rom_q,
    output logic                        rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]           rsp_data
);

    localparam int                c_id_w    = $clog2(NUM_REQ);
    localparam logic [c_id_w-1:0] c_last_id = c_id_w'(NUM_REQ - 1);

    logic [c_id_w-1:0]              r_ptr;
    logic [ADDR_W-1:0]              r_rom_addr;
    logic [DATA_W-1:0]              r_rsp_data;
    logic [ROM_LAT:0]               r_tag_v;
    logic [ROM_LAT:0][c_id_w-1:0]   r_tag_id;

    logic                           w_found;
    logic                           w_grant;
    logic [c_id_w-1:0]              w_idx;
    logic [c_id_w-1:0]              w_ptr_nxt;
    logic [ADDR_W-1:0]              w_sel_addr;

    // Two ascending passes (pointer..top, then 0..pointer-1) give the
    // circular search without a modulo.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req[i] && (c_id_w'(i) >= r_ptr)) begin
                w_found = 1'b1;
                w_idx   = c_id_w'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req[i] && (c_id_w'(i) < r_ptr)) begin
                w_found = 1'b1;
                w_idx   = c_id_w'(i);
            end
        end
`ifdef SPRITE_ARB_PRIO0_EN
        if (req[0]) begin
            w_found = 1'b1;
            w_idx   = '0;
        end
`endif
    end

    assign w_grant = w_found && !reset;

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_gnt
            assign gnt[g] = w_grant && (w_idx == c_id_w'(g));
        end
    endgenerate

    always_comb begin
        w_sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_idx == c_id_w'(i)) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_grant) begin
            w_ptr_nxt = (w_idx == c_last_id) ? '0 : w_idx + 1'b1;
        end
`ifdef SPRITE_ARB_PRIO0_EN
        // Scanout grants never disturb the round-robin order of the others.
        if (req[0]) begin
            w_ptr_nxt = r_ptr;
        end
`endif
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_rom_addr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
            if (w_grant) begin
                r_rom_addr <= w_sel_addr;
            end
        end
    end

    // Stage 0 travels alongside rom_addr; stage ROM_LAT is the response.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_tag_v[0]  <= w_grant;
            r_tag_id[0] <= w_idx;
            for (int s = 1; s <= ROM_LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_rsp_data <= '0;
        end else if (r_tag_v[ROM_LAT-1]) begin
            r_rsp_data <= rom_q;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign rsp_valid = r_tag_v[ROM_LAT];
    assign rsp_id    = r_tag_id[ROM_LAT];
    assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire
